adc_par_read_ctrl: RTL and testbench
====================================

Name: adc_par_read_ctrl

Overview:
Read-side controller for the board's 8-bit parallel ADC, the acquisition counterpart of the AD7302 DAC write path. It periodically starts a conversion and waits for BUSY to fall. It then drives CS/RD to read the result and presents each sample to the 7-segment/LCD display logic as a one-cycle valid pulse. A conversion-timeout error flag is provided.

Parameters:
SAMPLE_DIV, 50000, clk cycles between conversion starts (1 kHz at 50 MHz); legal range 64..65535
CONVST_W, 10, adc_convst_n low width in clk cycles; must be >=1
RD_W, 6, adc_rd_n low width in clk cycles; data is latched on the last low cycle; must be >=2
TIMEOUT, 1000, max clk cycles waiting for BUSY low before error; must be >=4

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous, active-low reset
en  in  1  acquisition enable (level)
clr_err  in  1  clears timeout_err (single-cycle pulse)
adc_d  in  8  ADC parallel data bus
adc_busy  in  1  ADC BUSY, active high, asynchronous to clk
adc_convst_n  out  1  conversion start, active low
adc_cs_n  out  1  chip select, active low
adc_rd_n  out  1  read strobe, active low
sample  out  8  last accepted sample
sample_valid  out  1  one-cycle pulse when sample updates
timeout_err  out  1  sticky conversion-timeout flag

Behaviour:
- Reset values: adc_convst_n=1, adc_cs_n=1, adc_rd_n=1, sample=0, sample_valid=0, timeout_err=0. State is IDLE and all counters are 0.
- adc_busy passes through a 2-FF synchronizer (busy_s). The state machine uses only busy_s.
- Rate counter runs only while en=1 and reloads to 0 when en=0. A start tick is generated when the count reaches SAMPLE_DIV-1, then the counter wraps to 0.
- IDLE: on a start tick, go to CONV. Ticks that arrive while not in IDLE are dropped; they are not queued.
- CONV: adc_convst_n=0 for exactly CONVST_W cycles, then go to WAIT_HI.
- WAIT_HI: wait for busy_s=1 (conversion acknowledged), then go to WAIT_LO.
- WAIT_LO: wait for busy_s=0, then go to READ.
- Timeout counter runs across WAIT_HI and WAIT_LO combined. If it reaches TIMEOUT: set timeout_err=1, skip the read, return to IDLE, no sample_valid.
- READ: adc_cs_n=0 and adc_rd_n=0 for RD_W cycles. adc_d is registered on the last low cycle. The next cycle releases adc_cs_n and adc_rd_n, updates sample, pulses sample_valid, and returns to IDLE.
- Latency: from the BUSY falling edge at the pin, sample_valid asserts within 2 (sync) + 1 + RD_W + 1 cycles.
- en deasserted mid-operation: the current conversion/read completes. No new start occurs.
- clr_err clears timeout_err. If a timeout and clr_err occur in the same cycle, set wins.
- Asynchronous reset mid-READ: strobes release immediately and sample returns to 0.
- adc_convst_n, adc_cs_n and adc_rd_n are driven directly from flops (glitch-free). Never assert convst_n and rd_n low together.

Optional Feature:
Macro ADC_AVG4_EN.
- Defined: the block accumulates 4 consecutive raw reads in a 10-bit sum. After the 4th read, sample = sum[9:2] (truncating) and sample_valid pulses once, so the output rate is 1/4 of the conversion rate. A timeout or en=0 discards any partial accumulation.
- Undefined: every raw read is output directly as described above.

Decomposition:
- Package adc_par_pkg: state enum (IDLE, CONV, WAIT_HI, WAIT_LO, READ), ADC_DW=8, counter-width constant (16 bits).
- One natural sub-module: adc_rate_tick (rate counter with enable and SAMPLE_DIV parameter). The FSM stays in the top.

Test Plan:
- Reset then en=1, SAMPLE_DIV=100, ADC model with BUSY high 40 cycles after convst_n falls, adc_d=8'hA5 -> convst_n low exactly 10 cycles, rd_n low 6 cycles, sample=8'hA5 with one sample_valid pulse, next convst_n 100 cycles after the previous one.
- ADC model returns 8'h00, 8'hFF, 8'h7F on successive conversions -> sample_valid pulses carry 00, FF, 7F in order; cs_n/rd_n high between reads.
- BUSY held low forever, TIMEOUT=1000 -> timeout_err=1 about 1000 cycles after WAIT_HI entry, no sample_valid; clr_err pulse -> 0; next tick retries.
- en dropped during WAIT_LO -> read completes and sample_valid fires once, then no further convst_n.
- rst_n asserted during READ -> rd_n/cs_n high in the same cycle, sample=0, FSM in IDLE.
- With ADC_AVG4_EN, reads 10, 20, 30, 41 -> single sample_valid with sample=25 (101>>2); no pulses for the first three reads.

Source files
------------

// File: rtl/adc_par_pkg.sv
// Shared types and constants for the parallel ADC read controller.
package adc_par_pkg;

    localparam int ADC_DW = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONV    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        READ    = 3'd4
    } state_t;

endpackage

// File: rtl/adc_rate_tick.sv
// Conversion-rate divider: one-cycle tick every SAMPLE_DIV clocks while en
// is high; the count is held at zero while en is low.
module adc_rate_tick
    import adc_par_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and tick decode.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_par_read_ctrl.sv
// Read-side controller for the 8-bit parallel ADC: periodic CONVST, BUSY
// handshake with timeout, CS/RD read strobe, one-cycle sample_valid.
// Optional build macro ADC_AVG4_EN: output the truncated mean of every
// four raw reads instead of each raw read.
module adc_par_read_ctrl
    import adc_par_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int CONVST_W   = 10,
    parameter int RD_W       = 6,
    parameter int TIMEOUT    = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr_err,
    input  logic [ADC_DW-1:0] adc_d,
    input  logic              adc_busy,
    output logic              adc_convst_n,
    output logic              adc_cs_n,
    output logic              adc_rd_n,
    output logic [ADC_DW-1:0] sample,
    output logic              sample_valid,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONVST_W - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_W - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic              busy_meta_q, busy_s_q;
    logic              convst_n_q, cs_n_q, rd_n_q;
    logic [ADC_DW-1:0] sample_q;
    logic              sample_valid_q;
    logic              timeout_err_q;
    logic              tick;
    logic              timeout_hit;
    logic              read_done;

    adc_rate_tick #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_rate (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    // Two-flop synchronizer for the asynchronous BUSY pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            busy_meta_q <= adc_busy;
            busy_s_q    <= busy_meta_q;
        end
    end

    // Next-state logic; the timeout counter spans both BUSY wait states.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        tmo_d       = tmo_q;
        timeout_hit = 1'b0;
        read_done   = 1'b0;
        case (state_q)
            IDLE: begin
                step_d = '0;
                tmo_d  = '0;
                if (tick) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (step_q == CONV_LAST) begin
                    step_d  = '0;
                    tmo_d   = '0;
                    state_d = WAIT_HI;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            WAIT_HI, WAIT_LO: begin
                if (state_q == WAIT_LO && !busy_s_q) begin
                    step_d  = '0;
                    state_d = READ;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    tmo_d       = '0;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (state_q == WAIT_HI && busy_s_q) begin
                        state_d = WAIT_LO;
                    end
                end
            end
            READ: begin
                if (step_q == RD_LAST) begin
                    read_done = 1'b1;
                    step_d    = '0;
                    state_d   = IDLE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and strobes; strobes decode the next state so they
    // come straight from flops and CONV/READ can never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            step_q     <= '0;
            tmo_q      <= '0;
            convst_n_q <= 1'b1;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            tmo_q      <= tmo_d;
            convst_n_q <= (state_d != CONV);
            cs_n_q     <= (state_d != READ);
            rd_n_q     <= (state_d != READ);
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
        end else if (clr_err) begin
            timeout_err_q <= 1'b0;
        end
    end

`ifdef ADC_AVG4_EN
    logic [ADC_DW+1:0] acc_q;
    logic [1:0]        acc_cnt_q;
    logic [ADC_DW+1:0] acc_sum;

    assign acc_sum = acc_q + {2'b00, adc_d};

    // Accumulate four reads, then emit sum/4; timeout or disable drops a partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q          <= '0;
            acc_cnt_q      <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            if (read_done) begin
                if (acc_cnt_q == 2'd3) begin
                    sample_q       <= acc_sum[ADC_DW+1:2];
                    sample_valid_q <= 1'b1;
                    acc_q          <= '0;
                    acc_cnt_q      <= '0;
                end else begin
                    acc_q     <= acc_sum;
                    acc_cnt_q <= acc_cnt_q + 1'b1;
                end
            end else if (timeout_hit || !en) begin
                acc_q     <= '0;
                acc_cnt_q <= '0;
            end
        end
    end
`else
    // Capture the bus on the last RD-low cycle and flag it for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= read_done;
            if (read_done) begin
                sample_q <= adc_d;
            end
        end
    end
`endif

    assign adc_convst_n = convst_n_q;
    assign adc_cs_n     = cs_n_q;
    assign adc_rd_n     = rd_n_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_adc_par_read_ctrl.sv
// Directed bench for adc_par_read_ctrl with a simple BUSY/data ADC model.
module tb_adc_par_read_ctrl;
    import adc_par_pkg::*;

    localparam int DIV = 100;
    localparam int CW  = 10;
    localparam int RW  = 6;
    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] adc_d = 8'h00;
    logic       adc_busy = 1'b0;
    logic       adc_convst_n, adc_cs_n, adc_rd_n;
    logic [7:0] sample;
    logic       sample_valid;
    logic       timeout_err;

    adc_par_read_ctrl #(
        .SAMPLE_DIV (DIV),
        .CONVST_W   (CW),
        .RD_W       (RW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clr_err      (clr_err),
        .adc_d        (adc_d),
        .adc_busy     (adc_busy),
        .adc_convst_n (adc_convst_n),
        .adc_cs_n     (adc_cs_n),
        .adc_rd_n     (adc_rd_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // ---------------- monitor (negedge sampling) ----------------
    int  conv_run = 0, rd_run = 0, last_conv_w = 0, last_rd_w = 0;
    int  rd_low_total = 0, conv_fall_cnt = 0, rd_fall_cnt = 0, valid_cnt = 0;
    int  overlap_cnt = 0, csrd_diff_cnt = 0;
    time conv_fall_t = 0, prev_conv_fall_t = 0, valid_t = 0, busy_fall_t = 0;
    logic conv_prev = 1'b1, rd_prev = 1'b1;
    logic [7:0] vq[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (!adc_convst_n) conv_run++;
            else if (!conv_prev) begin last_conv_w = conv_run; conv_run = 0; end
            if (!adc_rd_n) begin rd_run++; rd_low_total++; end
            else if (!rd_prev) begin last_rd_w = rd_run; rd_run = 0; end
            if (!adc_convst_n && conv_prev) begin
                conv_fall_cnt++;
                prev_conv_fall_t = conv_fall_t;
                conv_fall_t = $time;
            end
            if (!adc_rd_n && rd_prev) rd_fall_cnt++;
            if (sample_valid) begin
                valid_cnt++;
                valid_t = $time;
                vq.push_back(sample);
                $display("txn: sample_valid sample=%02h", sample);
            end
            if (!adc_convst_n && !adc_rd_n) overlap_cnt++;
            if (adc_cs_n !== adc_rd_n) csrd_diff_cnt++;
        end else begin
            conv_run = 0;
            rd_run = 0;
        end
        conv_prev = adc_convst_n;
        rd_prev = adc_rd_n;
    end

    // ---------------- ADC model ----------------
    logic       stuck = 1'b0;
    logic [7:0] dq[$];

    initial begin
        forever begin
            @(negedge adc_convst_n);
            if (dq.size() > 0) adc_d = dq.pop_front();
            if (!stuck) begin
                repeat (3) @(negedge clk);
                adc_busy = 1'b1;
                repeat (40) @(negedge clk);
                adc_busy = 1'b0;
                busy_fall_t = $time;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_valid(input int start, input int need, input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            if (valid_cnt >= start + need) break;
            step(1);
        end
        check_eq(tag, 32'(valid_cnt >= start + need), 32'd1);
    endtask

    int  v0, f0, r0, lat, dly;
    time t_fall, t_err;

    initial begin
        step(3);
        check_eq("rst_convst_n", 32'(adc_convst_n), 32'd1);
        check_eq("rst_cs_n", 32'(adc_cs_n), 32'd1);
        check_eq("rst_rd_n", 32'(adc_rd_n), 32'd1);
        check_eq("rst_sample", 32'(sample), 32'd0);
        check_eq("rst_valid", 32'(sample_valid), 32'd0);
        check_eq("rst_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        step(2);

`ifdef ADC_AVG4_EN
        dq.push_back(8'd10);
        dq.push_back(8'd20);
        dq.push_back(8'd30);
        dq.push_back(8'd41);
        v0 = valid_cnt;
        r0 = rd_fall_cnt;
        en = 1'b1;
        wait_valid(v0, 1, 1000, "avg_pulse");
        check_eq("avg_sample", 32'(sample), 32'd25);
        check_eq("avg_reads", 32'(rd_fall_cnt - r0), 32'd4);
        check_eq("avg_pulses", 32'(valid_cnt - v0), 32'd1);
        en = 1'b0;
        step(5);
`else
        // --- single conversion: strobe widths, data, latency, period ---
        dq.push_back(8'hA5);
        v0 = valid_cnt;
        en = 1'b1;
        wait_valid(v0, 1, 300, "t1_valid_seen");
        check_eq("t1_sample", 32'(sample), 32'hA5);
        check_eq("t1_convst_w", 32'(last_conv_w), 32'd10);
        check_eq("t1_rd_w", 32'(last_rd_w), 32'd6);
        lat = int'((valid_t - busy_fall_t) / 10);
        check_eq("t1_latency_le_10", 32'(lat >= 3 && lat <= 10), 32'd1);
        f0 = conv_fall_cnt;
        for (int i = 0; i < 200; i++) begin
            if (conv_fall_cnt > f0) break;
            step(1);
        end
        check_eq("t1_next_conv_seen", 32'(conv_fall_cnt > f0), 32'd1);
        check_eq("t1_period", 32'((conv_fall_t - prev_conv_fall_t) / 10), 32'd100);
        check_eq("t1_one_pulse", 32'(valid_cnt - v0), 32'd1);

        // --- three data patterns in sequence ---
        v0 = valid_cnt;
        wait_valid(v0, 1, 200, "t2_flush");
        dq.push_back(8'h00);
        dq.push_back(8'hFF);
        dq.push_back(8'h7F);
        vq.delete();
        v0 = valid_cnt;
        r0 = rd_low_total;
        wait_valid(v0, 3, 500, "t2_three_seen");
        check_eq("t2_s0", 32'(vq[0]), 32'h00);
        check_eq("t2_s1", 32'(vq[1]), 32'hFF);
        check_eq("t2_s2", 32'(vq[2]), 32'h7F);
        check_eq("t2_rd_low_total", 32'(rd_low_total - r0), 32'd18);
        check_eq("t2_no_overlap", 32'(overlap_cnt), 32'd0);
        check_eq("t2_cs_eq_rd", 32'(csrd_diff_cnt), 32'd0);

        // --- BUSY never rises: timeout, clear, retry ---
        stuck = 1'b1;
        f0 = conv_fall_cnt;
        for (int i = 0; i < 200; i++) begin
            if (conv_fall_cnt > f0) break;
            step(1);
        end
        check_eq("t3_conv_seen", 32'(conv_fall_cnt > f0), 32'd1);
        t_fall = conv_fall_t;
        dq.push_back(8'h3C);
        v0 = valid_cnt;
        for (int i = 0; i < 1200; i++) begin
            if (timeout_err) break;
            step(1);
        end
        t_err = $time;
        stuck = 1'b0;
        check_eq("t3_err_set", 32'(timeout_err), 32'd1);
        dly = int'((t_err - t_fall) / 10);
        check_eq("t3_err_delay", 32'(dly >= 1005 && dly <= 1015), 32'd1);
        check_eq("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
        check_eq("t3_strobes_idle", 32'(adc_convst_n & adc_rd_n), 32'd1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check_eq("t3_err_cleared", 32'(timeout_err), 32'd0);
        wait_valid(v0, 1, 300, "t3_retry_seen");
        check_eq("t3_retry_sample", 32'(sample), 32'h3C);

        // --- en dropped while waiting for BUSY low ---
        dq.push_back(8'h5A);
        for (int i = 0; i < 200; i++) begin
            if (adc_busy) break;
            step(1);
        end
        check_eq("t4_busy_seen", 32'(adc_busy), 32'd1);
        step(6);
        en = 1'b0;
        v0 = valid_cnt;
        f0 = conv_fall_cnt;
        wait_valid(v0, 1, 200, "t4_valid_seen");
        check_eq("t4_sample", 32'(sample), 32'h5A);
        step(300);
        check_eq("t4_one_pulse", 32'(valid_cnt - v0), 32'd1);
        check_eq("t4_no_new_conv", 32'(conv_fall_cnt - f0), 32'd0);

        // --- asynchronous reset in the middle of READ ---
        dq.push_back(8'h77);
        en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (!adc_rd_n) break;
            step(1);
        end
        check_eq("t5_rd_seen", 32'(adc_rd_n), 32'd0);
        step(2);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rd_n", 32'(adc_rd_n), 32'd1);
        check_eq("t5_cs_n", 32'(adc_cs_n), 32'd1);
        check_eq("t5_sample", 32'(sample), 32'd0);
        check_eq("t5_valid", 32'(sample_valid), 32'd0);
        check_eq("t5_state_idle", 32'(dut.state_q), 32'(IDLE));
        en = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
